// File: rtl/counter_pc_sequencer.sv
// ---------------------------------------------------------------------------
// counter_pc_sequencer
//   Run controller for a single counter_pc instance. A job (stop PC) is taken
//   over a valid/ready request port. The counter is held in reset for a clear
//   window, then released. The sequencer watches done, PC-max and a run-cycle
//   watchdog. The result (status, final PC, run cycles) is returned on a
//   valid/ready response port.
//
//   Optional feature macro: COUNTER_PC_SEQ_ABORT_EN
//     When defined, an abort_i input is added. Abort ends the job with status
//     11. When not defined, there is no abort port and status 11 is never
//     produced.
//
// Parameters
//   PC_W        width of PC and stop value
//   CLR_CYCLES  cycles cnt_rst_o is held before each run (>=1)
//   CYC_W       width of the saturating run-cycle counter
//   WDOG_CYCLES run-cycle limit before watchdog abort; 0 disables it
//
// Ports
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   req_valid_i     job request valid
//   req_ready_o     job can be accepted (IDLE only, combinational)
//   req_pc_stop_i   stop PC for the job
//   cnt_rst_o       active-high reset to counter_pc
//   cnt_pc_stop_o   registered stop PC to counter_pc
//   cnt_pc_i        current PC from counter_pc
//   cnt_done_i      done from counter_pc
//   abort_i         (COUNTER_PC_SEQ_ABORT_EN only) abort current job
//   rsp_valid_o     result valid
//   rsp_ready_i     result consumed
//   rsp_status_o    00 DONE, 01 PC_MAX, 10 WATCHDOG, 11 ABORTED
//   rsp_pc_o        cnt_pc_i captured on the terminating cycle
//   rsp_cycles_o    run cycles, including the terminating cycle
//   busy_o          high in CLEAR or RUN
// ---------------------------------------------------------------------------
module counter_pc_sequencer #(
    parameter int PC_W        = 16,
    parameter int CLR_CYCLES  = 2,
    parameter int CYC_W       = 18,
    parameter int WDOG_CYCLES = 131072
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [PC_W-1:0]  req_pc_stop_i,
    output logic             cnt_rst_o,
    output logic [PC_W-1:0]  cnt_pc_stop_o,
    input  logic [PC_W-1:0]  cnt_pc_i,
    input  logic             cnt_done_i,
`ifdef COUNTER_PC_SEQ_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [1:0]       rsp_status_o,
    output logic [PC_W-1:0]  rsp_pc_o,
    output logic [CYC_W-1:0] rsp_cycles_o,
    output logic             busy_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CLEAR  = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam logic [1:0] ST_DONE  = 2'b00;
    localparam logic [1:0] ST_PCMAX = 2'b01;
    localparam logic [1:0] ST_WDOG  = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

    localparam int             CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_INIT = CLR_W'(CLR_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CLR_W-1:0] clr_q, clr_d;
    logic [CYC_W-1:0] cyc_q, cyc_d, cyc_inc;
    logic [PC_W-1:0]  stop_q, stop_d;
    logic             cnt_rst_q, cnt_rst_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       status_q, status_d;
    logic [PC_W-1:0]  rpc_q, rpc_d;
    logic [CYC_W-1:0] rcyc_q, rcyc_d;
    logic             abort_w, wdog_hit, pc_max;

`ifdef COUNTER_PC_SEQ_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // Saturating run-cycle count including the current RUN cycle.
    assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);
    assign pc_max  = &cnt_pc_i;

    // cyc_q holds the number of completed RUN cycles. Matching WDOG_CYCLES-1
    // therefore fires on the WDOG_CYCLES-th RUN cycle.
    generate
        if (WDOG_CYCLES != 0) begin : g_wdog
            assign wdog_hit = (64'(cyc_q) == 64'(WDOG_CYCLES) - 64'd1);
        end else begin : g_no_wdog
            assign wdog_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        cyc_d       = cyc_q;
        stop_d      = stop_q;
        cnt_rst_d   = cnt_rst_q;
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        status_d    = status_q;
        rpc_d       = rpc_q;
        rcyc_d      = rcyc_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    stop_d    = req_pc_stop_i;
                    cyc_d     = '0;
                    clr_d     = CLR_INIT;
                    cnt_rst_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort_w) begin
                    // The counter never ran, so PC and cycle count are zero.
                    status_d    = ST_ABORT;
                    rpc_d       = '0;
                    rcyc_d      = cyc_q;
                    rsp_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_REPORT;
                end else if (clr_q == '0) begin
                    cnt_rst_d = 1'b0;
                    state_d   = S_RUN;
                end else begin
                    clr_d = clr_q - CLR_W'(1);
                end
            end
            S_RUN: begin
                cyc_d = cyc_inc;
                if (cnt_done_i || pc_max || wdog_hit || abort_w) begin
                    if (cnt_done_i)    status_d = ST_DONE;
                    else if (pc_max)   status_d = ST_PCMAX;
                    else if (wdog_hit) status_d = ST_WDOG;
                    else               status_d = ST_ABORT;
                    rpc_d       = cnt_pc_i;
                    rcyc_d      = cyc_inc;
                    rsp_valid_d = 1'b1;
                    cnt_rst_d   = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_REPORT;
                end
            end
            default: begin // S_REPORT
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            clr_q       <= '0;
            cyc_q       <= '0;
            stop_q      <= '0;
            cnt_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            status_q    <= '0;
            rpc_q       <= '0;
            rcyc_q      <= '0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            cyc_q       <= cyc_d;
            stop_q      <= stop_d;
            cnt_rst_q   <= cnt_rst_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            status_q    <= status_d;
            rpc_q       <= rpc_d;
            rcyc_q      <= rcyc_d;
        end
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign cnt_rst_o     = cnt_rst_q;
    assign cnt_pc_stop_o = stop_q;
    assign busy_o        = busy_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_status_o  = status_q;
    assign rsp_pc_o      = rpc_q;
    assign rsp_cycles_o  = rcyc_q;

endmodule
